// File: rtl/chrono_counter.sv
// rtl/chrono_counter.sv - stopwatch time base: centisecond prescaler, SS.cc BCD count, run/pause/clear/lap control
module chrono_counter #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] data,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_s1, r_s0, r_c1, r_c0;
    logic [15:0]   r_lap;
    logic          r_hold;
    logic          r_wrap;

    logic [15:0]   w_count;
    logic          w_in_run;
    logic          w_in_pause;
    logic          w_clear_now;
    logic          w_presc_last;
    logic          w_tick;
    logic          w_wrap_now;

    assign w_count      = {r_s1, r_s0, r_c1, r_c0};
    assign w_in_run     = (r_state == S_RUN);
    assign w_in_pause   = (r_state == S_PAUSE);
    assign w_clear_now  = w_in_pause && clear;
    assign w_presc_last = (r_presc == PW'(DIV - 1));
    assign w_tick       = w_in_run && w_presc_last;
    assign w_wrap_now   = w_tick && (w_count == 16'h5999);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // clear takes priority over start_stop while paused
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_stop) w_next = S_RUN;
            S_RUN:   if (start_stop) w_next = S_PAUSE;
            S_PAUSE: begin
                if (clear)           w_next = S_IDLE;
                else if (start_stop) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        running    = w_in_run;
        lap_active = r_hold;
        wrap       = r_wrap;
        data       = r_hold ? r_lap : w_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
            r_c1    <= 4'd0;
            r_c0    <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_now;
            if (w_clear_now) begin
                r_presc <= '0;
                r_s1    <= 4'd0;
                r_s0    <= 4'd0;
                r_c1    <= 4'd0;
                r_c0    <= 4'd0;
            end else if (w_in_run) begin
                r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
                // ripple carry C0 -> C1 -> S0 -> S1, S1 rolls over after 5
                if (w_tick) begin
                    if (r_c0 == 4'd9) begin
                        r_c0 <= 4'd0;
                        if (r_c1 == 4'd9) begin
                            r_c1 <= 4'd0;
                            if (r_s0 == 4'd9) begin
                                r_s0 <= 4'd0;
                                r_s1 <= (r_s1 == 4'd5) ? 4'd0 : r_s1 + 4'd1;
                            end else begin
                                r_s0 <= r_s0 + 4'd1;
                            end
                        end else begin
                            r_c1 <= r_c1 + 4'd1;
                        end
                    end else begin
                        r_c0 <= r_c0 + 4'd1;
                    end
                end
            end
        end
    end

    // lap captures the pre-increment count only while running; pause may only release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_lap  <= 16'h0000;
        end else if (w_clear_now) begin
            r_hold <= 1'b0;
        end else if (w_in_run && lap) begin
            if (!r_hold) begin
                r_lap  <= w_count;
                r_hold <= 1'b1;
            end else begin
                r_hold <= 1'b0;
            end
        end else if (w_in_pause && lap) begin
            r_hold <= 1'b0;
        end
    end
endmodule

// File: tb/tb_chrono_counter.sv
// tb/tb_chrono_counter.sv - self-checking bench for chrono_counter against an elapsed-ticks model
module tb_chrono_counter;
    localparam int DIV = 10;

    logic        clk;
    logic        rst;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] data;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int n_checks = 0;
    int n_pass   = 0;

    // model: 0 idle, 1 run, 2 pause; time kept as whole centiseconds
    int m_state = 0;
    int m_phase = 0;
    int m_ticks = 0;
    int m_hold  = 0;
    int m_lap   = 0;
    int m_wrap  = 0;

    chrono_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .data       (data),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int t);
        int s, c;
        s = t / 100;
        c = t % 100;
        return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {to_bcd(m_hold != 0 ? m_lap : m_ticks), m_state == 1, m_hold != 0, m_wrap != 0};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {data, running, lap_active, wrap};
    endfunction

    task automatic model_edge(input logic ss, input logic cl, input logic lp, input logic r);
        int pre;
        bit tick;
        if (r) begin
            m_state = 0; m_phase = 0; m_ticks = 0; m_hold = 0; m_lap = 0; m_wrap = 0;
        end else begin
            pre  = m_ticks;
            tick = 0;
            if (m_state == 1) begin
                m_phase = (m_phase + 1) % DIV;
                tick = (m_phase == 0);
                if (lp) begin
                    if (m_hold == 0) begin m_lap = pre; m_hold = 1; end
                    else m_hold = 0;
                end
            end else if (m_state == 2 && lp) begin
                m_hold = 0;
            end
            if (tick) m_ticks = (pre + 1) % 6000;
            m_wrap = (tick && pre == 5999) ? 1 : 0;
            case (m_state)
                0: if (ss) m_state = 1;
                1: if (ss) m_state = 2;
                default: begin
                    if (cl) begin
                        m_state = 0; m_ticks = 0; m_phase = 0; m_hold = 0;
                    end else if (ss) begin
                        m_state = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic ss, input logic cl, input logic lp, input logic r);
        start_stop = ss; clear = cl; lap = lp; rst = r;
        @(posedge clk);
        model_edge(ss, cl, lp, r);
        #1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_checks++;
        if (obs_vec() !== 19'h0) $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 19'h0);
        else n_pass++;
        step(0, 1, 1, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL idle_ignores_clear_lap: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_first_tick();
        int bad = 0;
        step(1, 0, 0, 0);
        n_checks++;
        if (running !== 1'b1) $display("FAIL run_entry: got running=%b expected 1", running);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 0);
            if (obs_vec() !== exp_vec()) bad++;
        end
        n_checks++;
        if (data !== 16'h0010) $display("FAIL first_100_cycles: got %h expected 0010", data);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL first_tick_trace: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int wrap_cycles = 0;
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 59990; i++) step(0, 0, 0, 0);
        n_checks++;
        if (data !== 16'h5999) $display("FAIL count_5999: got %h expected 5999", data);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (wrap === 1'b1) wrap_cycles++;
        end
        n_checks++;
        if (data !== 16'h0000 || wrap !== 1'b1)
            $display("FAIL wrap_rollover: got data=%h wrap=%b expected data=0000 wrap=1", data, wrap);
        else n_pass++;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0);
            if (wrap === 1'b1) wrap_cycles++;
        end
        n_checks++;
        if (wrap_cycles != 1) $display("FAIL wrap_width: got %0d cycles expected 1", wrap_cycles);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL after_wrap: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        logic [15:0] d0;
        int k = 0;
        int moved = 0;
        for (int i = 0; i < 20 && m_phase != 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        d0 = data;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0);
            if (data !== d0 || running !== 1'b0) moved++;
        end
        n_checks++;
        if (moved != 0) $display("FAIL pause_hold: got %0d changed cycles expected 0", moved);
        else n_pass++;
        step(1, 0, 0, 0);
        while (k < 20) begin
            step(0, 0, 0, 0);
            k++;
            if (data !== d0) break;
        end
        n_checks++;
        if (k != 6) $display("FAIL resume_latency: got %0d cycles expected 6", k);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL resume_value: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_lap();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 1230; i++) step(0, 0, 0, 0);
        n_checks++;
        if (data !== 16'h0123) $display("FAIL pre_lap: got %h expected 0123", data);
        else n_pass++;
        step(0, 0, 1, 0);
        n_checks++;
        if (data !== 16'h0123 || lap_active !== 1'b1)
            $display("FAIL lap_capture: got data=%h lap_active=%b expected 0123 1", data, lap_active);
        else n_pass++;
        for (int i = 0; i < 299; i++) step(0, 0, 0, 0);
        n_checks++;
        if (data !== 16'h0123) $display("FAIL lap_frozen: got %h expected 0123", data);
        else n_pass++;
        step(0, 0, 1, 0);
        n_checks++;
        if (data !== 16'h0153 || lap_active !== 1'b0)
            $display("FAIL lap_release: got data=%h lap_active=%b expected 0153 0", data, lap_active);
        else n_pass++;
    endtask

    task automatic test_clear();
        step(0, 1, 0, 0);
        n_checks++;
        if (running !== 1'b1 || obs_vec() !== exp_vec())
            $display("FAIL clear_in_run: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        n_checks++;
        if (data !== 16'h0000 || running !== 1'b0)
            $display("FAIL clear_wins: got data=%h running=%b expected 0000 0", data, running);
        else n_pass++;
        step(0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL idle_after_clear: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        step(1, 0, 0, 0);
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
        n_checks++;
        if (lap_active !== 1'b1) $display("FAIL hold_before_reset: got %b expected 1", lap_active);
        else n_pass++;
        step(0, 0, 0, 1);
        n_checks++;
        if (obs_vec() !== 19'h0) $display("FAIL reset_midrun: got %h expected %h", obs_vec(), 19'h0);
        else n_pass++;
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== 19'h0) $display("FAIL stays_idle: got %h expected %h", obs_vec(), 19'h0);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        logic ss, cl, lp, r;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            ss = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 29) == 0);
            lp = ($urandom_range(0, 24) == 0);
            step(ss, cl, lp, r);
            if (obs_vec() !== exp_vec()) begin
                if (bad < 5) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs_vec(), exp_vec());
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL random_total: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        test_reset();
        test_first_tick();
        test_wrap();
        test_pause_resume();
        test_lap();
        test_clear();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
